// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings and FSM state type.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_bit_cell.sv
// One-bit ALU slice, purely combinational.
// Ports: a_bit, b_bit - operand bits; cin - incoming carry; op - operation select;
//        y_bit - result bit; cout_bit - carry out (0 for logical ops).
module alu_bit_cell
    import alu_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       y_bit,
    output logic       cout_bit
);

    logic b_eff;
    logic sum;
    logic carry;

    // Subtraction is a + ~b + 1; the +1 comes from the initial carry.
    assign b_eff = (op == OP_SUB) ? ~b_bit : b_bit;
    assign sum   = a_bit ^ b_eff ^ cin;
    assign carry = (a_bit & b_eff) | (cin & (a_bit ^ b_eff));

    always_comb begin
        y_bit    = 1'b0;
        cout_bit = 1'b0;
        case (op)
            OP_ADD,
            OP_SUB:  begin y_bit = sum; cout_bit = carry; end
            OP_AND:  y_bit = a_bit & b_bit;
            OP_OR:   y_bit = a_bit | b_bit;
            OP_XOR:  y_bit = a_bit ^ b_bit;
            OP_NAND: y_bit = ~(a_bit & b_bit);
            OP_NOR:  y_bit = ~(a_bit | b_bit);
            OP_XNOR: y_bit = ~(a_bit ^ b_bit);
            default: y_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial ALU: accepts a request, evaluates one bit per cycle LSB first,
// and presents the result with a valid/ready handshake.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b, op request;
//        out_valid/out_ready + y, cout result.
// Optional: define ALU_SEQ_ZFLAG_EN to add output z (y == 0), registered with y.
module alu_bit_serial_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    output logic             z
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             y_bit;
    logic             cout_bit;
    logic             last;
    logic [WIDTH-1:0] y_next;

    // Operands shift right each cycle, so bit 0 is always the current bit.
    alu_bit_cell u_cell (
        .a_bit   (a_sh[0]),
        .b_bit   (b_sh[0]),
        .cin     (carry),
        .op      (op_r),
        .y_bit   (y_bit),
        .cout_bit(cout_bit)
    );

    assign last   = (cnt == CW'(WIDTH - 1));
    // Result enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
    assign y_next = {y_bit, y[WIDTH-1:1]};

    // Control FSM with datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            op_r      <= OP_ADD;
`ifdef ALU_SEQ_ZFLAG_EN
            z         <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_r     <= op;
                        carry    <= (op == OP_SUB);
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= cout_bit;
                    y     <= y_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cout      <= cout_bit;
`ifdef ALU_SEQ_ZFLAG_EN
                        z         <= (y_next == '0);
`endif
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Self-checking bench for alu_bit_serial_seq (WIDTH = 8).
module tb_alu_bit_serial_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         cout;
`ifdef ALU_SEQ_ZFLAG_EN
    logic         z;
`endif

    int checks = 0;
    int errors = 0;

    alu_bit_serial_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .cout     (cout)
`ifdef ALU_SEQ_ZFLAG_EN
        ,
        .z        (z)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   vop;
        logic [W-1:0] ey;
        logic         ecout;
        string        name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one request, measure latency, check the result, optionally consume it.
    task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [2:0] iop, input logic [W-1:0] ey, input logic ecout,
                          input bit consume);
        int lat;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(W));
        check({name, "_y"}, 32'(y), 32'(ey));
        check({name, "_cout"}, 32'(cout), 32'(ecout));
`ifdef ALU_SEQ_ZFLAG_EN
        check({name, "_z"}, 32'(z), 32'(ey == '0));
`endif
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            check({name, "_ov_drop"}, 32'(out_valid), 32'd0);
            check({name, "_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [W-1:0] hy;
        logic         hc;
        int           seen;

        vecs[0]  = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, "add_ff_01"};
        vecs[1]  = '{8'h05, 8'h07, 3'b001, 8'hFE, 1'b0, "sub_05_07"};
        vecs[2]  = '{8'h07, 8'h05, 3'b001, 8'h02, 1'b1, "sub_07_05"};
        vecs[3]  = '{8'hF0, 8'hCC, 3'b101, 8'h3F, 1'b0, "nand"};
        vecs[4]  = '{8'hAA, 8'hAA, 3'b111, 8'hFF, 1'b0, "xnor"};
        vecs[5]  = '{8'hF0, 8'hCC, 3'b010, 8'hC0, 1'b0, "and"};
        vecs[6]  = '{8'hF0, 8'hCC, 3'b011, 8'hFC, 1'b0, "or"};
        vecs[7]  = '{8'hF0, 8'hCC, 3'b100, 8'h3C, 1'b0, "xor"};
        vecs[8]  = '{8'hF0, 8'hCC, 3'b110, 8'h03, 1'b0, "nor"};
        vecs[9]  = '{8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, "add_7f_01"};
        vecs[10] = '{8'h42, 8'h42, 3'b001, 8'h00, 1'b1, "sub_42_42"};
        vecs[11] = '{8'h00, 8'h01, 3'b001, 8'hFF, 1'b0, "sub_00_01"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vop,
                   vecs[i].ey, vecs[i].ecout, 1'b1);

        // Back-pressure: result held for 5 cycles; input changes during RUN ignored.
        @(negedge clk);
        a = 8'h30; b = 8'h0F; op = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 8'h00; b = 8'h00; op = 3'b111;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 40) begin
            @(posedge clk);
            #1 seen++;
        end
        check("hold_y0", 32'(y), 32'h3F);
        check("hold_cout0", 32'(cout), 32'd0);
        hy = y; hc = cout;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_y_%0d", k), 32'(y), 32'(hy));
            check($sformatf("hold_cout_%0d", k), 32'(cout), 32'(hc));
            check($sformatf("hold_ov_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("hold_ir_%0d", k), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("hold_ir_after", 32'(in_ready), 32'd1);
        check("hold_ov_after", 32'(out_valid), 32'd0);

        // Reset mid-RUN: operation aborted, no result ever emitted.
        @(negedge clk);
        a = 8'h55; b = 8'h11; op = 3'b000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_y", 32'(y), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ov", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("abort_ir", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op("post_abort_add", 8'h10, 8'h20, 3'b000, 8'h30, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
